// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative radix-2 MULT/MULTU/DIV/DIVU sequencer that stalls EX and issues a HI/LO write.
// Optional macro MDU_FAST_MUL_EN: single-cycle W x W multiply; divide stays iterative.
module mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    input  logic              flush,
    output logic              stall_o,
    output logic              busy,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

`ifdef MDU_FAST_MUL_EN
    localparam state_t MUL_NEXT = S_DONE;
`else
    localparam state_t MUL_NEXT = S_MUL;
`endif

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_acc_hi, r_acc_lo, r_opb;
    logic                r_neg_q, r_neg_r;

    logic                w_accept, w_signed, w_is_div, w_div0, w_last, w_run;
    logic                w_a_neg, w_b_neg;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b;
    logic [DATA_W:0]     w_mul_sum, w_div_sh, w_div_diff;
    logic [DATA_W-1:0]   w_step_hi, w_step_lo;
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_q_fix, w_r_fix;
`ifdef MDU_FAST_MUL_EN
    logic [2*DATA_W-1:0] w_fast_mag, w_fast_prod;
`endif

    // Operand decode: signed ops iterate on magnitudes and remember result signs.
    always_comb begin
        w_signed = ~op[0];
        w_is_div = op[1];
        w_a_neg  = w_signed & srca[DATA_W-1];
        w_b_neg  = w_signed & srcb[DATA_W-1];
        w_mag_a  = w_a_neg ? -srca : srca;
        w_mag_b  = w_b_neg ? -srcb : srcb;
        w_div0   = w_is_div & (srcb == '0);
        w_accept = (r_state == S_IDLE) & start & ~flush;
        w_last   = (r_cnt == LAST);
        w_run    = (r_state == S_MUL) | (r_state == S_DIV);
    end

`ifdef MDU_FAST_MUL_EN
    always_comb begin
        w_fast_mag  = (2*DATA_W)'(w_mag_a) * (2*DATA_W)'(w_mag_b);
        w_fast_prod = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
    end
`endif

    // One datapath step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
        w_div_sh   = {r_acc_hi, r_acc_lo[DATA_W-1]};
        w_div_diff = w_div_sh - {1'b0, r_opb};
        if (r_state == S_DIV) begin
            w_step_hi = w_div_diff[DATA_W] ? w_div_sh[DATA_W-1:0] : w_div_diff[DATA_W-1:0];
            w_step_lo = {r_acc_lo[DATA_W-2:0], ~w_div_diff[DATA_W]};
        end else begin
            w_step_hi = w_mul_sum[DATA_W:1];
            w_step_lo = {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
        end
        w_prod_fix = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
        w_q_fix    = r_neg_q ? -w_step_lo : w_step_lo;
        w_r_fix    = r_neg_r ? -w_step_hi : w_step_hi;
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_div0)        w_next = S_DONE;
                        else if (w_is_div) w_next = S_DIV;
                        else               w_next = MUL_NEXT;
                    end
                end
                S_MUL, S_DIV: if (w_last) w_next = S_DONE;
                S_DONE:       w_next = S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        stall_o = resetn & (w_accept | w_run);
        hilo_we = resetn & (r_state == S_DONE) & ~flush;
    end

    // Results land in hi_o/lo_o on entry to DONE so they are valid with hilo_we.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= w_is_div ? w_mag_a : w_mag_b;
            r_opb    <= w_is_div ? w_mag_b : w_mag_a;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_div0) begin
                hi_o <= srca;
                lo_o <= '1;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!w_is_div) begin
                {hi_o, lo_o} <= w_fast_prod;
            end
`endif
        end else if (w_run && !flush) begin
            r_cnt    <= r_cnt + 1'b1;
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
            if (w_last) begin
                if (r_state == S_DIV) begin
                    hi_o <= w_r_fix;
                    lo_o <= w_q_fix;
                end else begin
                    {hi_o, lo_o} <= w_prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: fixed vector table, randomized ops against an arithmetic model,
// and hand sequences for flush, reset and back-to-back issue.
module tb_mdu_ctrl;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] srca = '0, srcb = '0;
    logic         stall_o, busy, hilo_we;
    logic [W-1:0] hi_o, lo_o;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .stall_o(stall_o), .busy(busy), .hilo_we(hilo_we),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Plain-arithmetic reference: 64-bit products and SV truncating division.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l, output int lat);
        longint          sa, sb, r64;
        longint unsigned ua, ub, u64;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        lat = o[1] ? DIV_LAT : MUL_LAT;
        h   = '0;
        l   = '0;
        if (o[1] && b == 0) begin
            h   = a;
            l   = '1;
            lat = 1;
        end else begin
            case (o)
                2'b00: begin r64 = sa * sb; {h, l} = r64; end
                2'b01: begin u64 = ua * ub; {h, l} = u64; end
                2'b10: begin h = 32'(sa % sb); l = 32'(sa / sb); end
                default: begin h = 32'(ua % ub); l = 32'(ua / ub); end
            endcase
        end
    endfunction

    // Called at a negedge with the DUT idle; returns one cycle after the write (DUT idle again).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int elat, input string nm);
        int k;
        bit seen, stall_ok;
        start = 1'b1; op = o; srca = a; srcb = b;
        #1;
        stall_ok = (stall_o === 1'b1);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 4*W) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (hilo_we === 1'b1) seen = 1'b1;
            else if (stall_o !== 1'b1) stall_ok = 1'b0;
        end
        chk({nm, ".lat"}, 64'(k), 64'(elat));
        chk({nm, ".stall"}, 64'(stall_ok && (stall_o === 1'b0)), 64'd1);
        chk({nm, ".hilo"}, {hi_o, lo_o}, {ehi, elo});
        @(negedge clk);
        chk({nm, ".hold"}, {hi_o, lo_o, 1'b0, busy, hilo_we}, {ehi, elo, 3'b000});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, eh, el;
        logic [1:0]  o;
        int          lat, nwr, c, t0, t1;
        logic [63:0] v0, v1;

        tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
        tbl[1]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        tbl[3]  = '{2'b11, 32'd100,      32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1};
        tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        tbl[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, DIV_LAT};
        tbl[6]  = '{2'b11, 32'd9,        32'd4,        32'h00000001, 32'h00000002, DIV_LAT};
        tbl[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
        tbl[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
        tbl[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        tbl[10] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, MUL_LAT};
        tbl[11] = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, DIV_LAT};

        // Reset: start asserted must not stall while resetn is low.
        resetn = 1'b0; start = 1'b1; op = 2'b11; srca = 32'd100; srcb = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset", {hi_o, lo_o, 1'b0, stall_o, busy, hilo_we}, 68'd0);
        start = 1'b0;
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].lat,
                   $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(3));
            a = (($urandom_range(9)) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(15));
                default: b = $urandom;
            endcase
            ref_model(o, a, b, eh, el, lat);
            run_op(o, a, b, eh, el, lat, $sformatf("rnd%0d", i));
        end

        // Flush at T+10 of a divide: no write, idle at T+11, new op accepted at T+11.
        start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd7;
        nwr = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (hilo_we === 1'b1) nwr++;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_mid", {nwr[31:0], 29'd0, stall_o, busy, hilo_we}, 64'd0);
        run_op(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, DIV_LAT, "after_flush");

        // Flush coincident with start is rejected.
        start = 1'b1; flush = 1'b1; op = 2'b11; srca = 32'd50; srcb = 32'd5;
        #1;
        chk("flush_start.stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start.idle", {62'd0, busy, hilo_we}, 64'd0);

        // Flush in DONE suppresses the write strobe.
        start = 1'b1; op = 2'b11; srca = 32'd5; srcb = 32'd0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_done.we", 64'(hilo_we), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done.idle", {62'd0, busy, hilo_we}, 64'd0);

        // Make hi_o/lo_o nonzero, then reset at T+5 of a divide.
        run_op(2'b11, 32'd77, 32'd10, 32'd7, 32'd7, DIV_LAT, "pre_reset");
        start = 1'b1; op = 2'b10; srca = 32'hFFFFFF9C; srcb = 32'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("reset_mid.stall", 64'(stall_o), 64'd0);
        @(negedge clk);
        chk("reset_mid.outs", {hi_o, lo_o, 1'b0, stall_o, busy, hilo_we}, 68'd0);
        resetn = 1'b1;
        nwr = 0;
        repeat (40) begin
            @(negedge clk);
            if (hilo_we === 1'b1) nwr++;
        end
        chk("reset_mid.nowrite", 64'(nwr), 64'd0);

        // Back-to-back DIVU 9/4 with start held: two writes 34 cycles apart.
        start = 1'b1; op = 2'b11; srca = 32'd9; srcb = 32'd4;
        nwr = 0; t0 = 0; t1 = 0; v0 = '0; v1 = '0;
        c = 0;
        while (c < 120) begin
            @(negedge clk);
            c++;
            if (hilo_we === 1'b1) begin
                nwr++;
                if (nwr == 1) begin t0 = c; v0 = {hi_o, lo_o}; end
                if (nwr == 2) begin t1 = c; v1 = {hi_o, lo_o}; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("b2b.count", 64'(nwr), 64'd2);
        chk("b2b.first_lat", 64'(t0), 64'(DIV_LAT));
        chk("b2b.gap", 64'(t1 - t0), 64'd34);
        chk("b2b.val0", v0, {32'd1, 32'd2});
        chk("b2b.val1", v1, {32'd1, 32'd2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
